// File: rtl/ip_codma_bus_arbiter.sv
`timescale 1ns / 1ps
// ip_codma_bus_arbiter
//   Round-robin owner of the single codma system bus. Requester 0 is the DMA read
//   machine, requester 1 the write machine; extra requesters are optional. The owner
//   keeps the bus until its burst completes or is aborted. Completion, bus error,
//   timeout and illegal size are reported back as one-cycle pulses.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   req_i[NUM_REQ]            level request, held until done_o / error_o
//   size_i[NUM_REQ*4]         size code per requester, slice [4i+3:4i]
//   write_i[NUM_REQ]          direction per requester, 1 = write
//   grant_o[NUM_REQ]          one-hot, owner may move data beats
//   done_o / error_o          one-cycle completion / abort pulses
//   bus_req_o, bus_write_o,
//   bus_size_o[4]             request, direction and size code towards the bus
//   bus_grant_i, bus_valid_i,
//   bus_error_i               bus grant, one 64-bit beat moved, bus error
//   busy_o                    arbiter not idle
//   owner_o[OW]               index of current / last owner
module ip_codma_bus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned OW      = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*4-1:0] size_i,
  input  logic [NUM_REQ-1:0]   write_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [NUM_REQ-1:0]   error_o,
  output logic                 bus_req_o,
  output logic                 bus_write_o,
  output logic [3:0]           bus_size_o,
  input  logic                 bus_grant_i,
  input  logic                 bus_valid_i,
  input  logic                 bus_error_i,
  output logic                 busy_o,
  output logic [OW-1:0]        owner_o
);

  typedef enum logic [1:0] {ArbIdle, ArbReq, ArbXfer, ArbDone} arb_state_e;

  localparam logic [15:0] TmoLimit = 16'(TIMEOUT);

  arb_state_e           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [3:0]           size_q, size_d;
  logic                 write_q, write_d;
  logic [1:0]           beat_q, beat_d;
  logic [15:0]          tmo_q, tmo_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   error_q, error_d;

  logic                 pick_valid;
  logic [OW-1:0]        pick_idx;
  logic [OW-1:0]        cand;
  logic [3:0]           pick_size;
  logic                 pick_write;
  logic                 abort;

  // Beats of 64 bits per size code; 0 marks an illegal code.
  function automatic logic [2:0] beats_of(input logic [3:0] code);
    case (code)
      4'd3:    beats_of = 3'd1;
      4'd8:    beats_of = 3'd2;
      4'd9:    beats_of = 3'd4;
      default: beats_of = 3'd0;
    endcase
  endfunction

  // First active request searching upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    pick_size  = '0;
    pick_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = OW'((32'(ptr_q) + i) % NUM_REQ);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (pick_idx == OW'(j)) begin
        pick_size  = size_i[4*j +: 4];
        pick_write = write_i[j];
      end
    end
  end

  // Bus error outranks the final beat; timeout behaves exactly like a bus error.
  assign abort = bus_error_i || (tmo_q == TmoLimit);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    size_d  = size_q;
    write_d = write_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    done_d  = '0;
    error_d = '0;
    unique case (state_q)
      ArbIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          size_d  = pick_size;
          write_d = pick_write;
          beat_d  = '0;
          tmo_d   = '0;
          if (beats_of(pick_size) == 3'd0) begin
            // Illegal size never reaches the bus.
            state_d           = ArbDone;
            error_d[pick_idx] = 1'b1;
          end else begin
            state_d = ArbReq;
          end
        end
      end
      ArbReq: begin
        if (abort) begin
          state_d          = ArbDone;
          error_d[owner_q] = 1'b1;
          beat_d           = '0;
          tmo_d            = '0;
        end else if (!req_i[owner_q]) begin
          state_d = ArbIdle;
        end else if (bus_grant_i) begin
          state_d = ArbXfer;
          beat_d  = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ArbXfer: begin
        if (abort) begin
          state_d          = ArbDone;
          error_d[owner_q] = 1'b1;
          beat_d           = '0;
          tmo_d            = '0;
        end else if (bus_valid_i) begin
          tmo_d = '0;
          if ({1'b0, beat_q} == beats_of(size_q) - 3'd1) begin
            state_d         = ArbDone;
            done_d[owner_q] = 1'b1;
            beat_d          = '0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ArbDone: begin
        state_d = ArbIdle;
        if (32'(owner_q) == NUM_REQ - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + OW'(1);
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ArbIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      beat_q  <= '0;
      tmo_q   <= '0;
      done_q  <= '0;
      error_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      size_q  <= size_d;
      write_q <= write_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    grant_o = '0;
    grant_o[owner_q] = (state_q == ArbXfer);
  end

  assign done_o      = done_q;
  assign error_o     = error_q;
  assign bus_req_o   = (state_q == ArbReq) || (state_q == ArbXfer);
  assign bus_write_o = bus_req_o & write_q;
  assign bus_size_o  = bus_req_o ? size_q : 4'd0;
  assign busy_o      = (state_q != ArbIdle);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
`timescale 1ns / 1ps
// Bench for ip_codma_bus_arbiter: directed scenarios with literal expectations,
// then randomized requesters and bus, all checked each cycle against a
// transaction-level model of the arbitration rules.
module tb_ip_codma_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;
  localparam int OW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*4-1:0] size = '0;
  logic [N-1:0]   wr = '0;
  logic           bus_grant = 1'b0, bus_valid = 1'b0, bus_error = 1'b0;
  logic [N-1:0]   grant_o, done_o, error_o;
  logic           bus_req_o, bus_write_o, busy_o;
  logic [3:0]     bus_size_o;
  logic [OW-1:0]  owner_o;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ip_codma_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req), .size_i(size), .write_i(wr),
    .grant_o(grant_o), .done_o(done_o), .error_o(error_o), .bus_req_o(bus_req_o),
    .bus_write_o(bus_write_o), .bus_size_o(bus_size_o), .bus_grant_i(bus_grant),
    .bus_valid_i(bus_valid), .bus_error_i(bus_error), .busy_o(busy_o), .owner_o(owner_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting for bus grant, 2 moving beats, 3 bubble after burst
  int m_phase = 0, m_owner = 0, m_ptr = 0, m_size = 0, m_write = 0;
  int m_tmo = 0, m_moved = 0, m_pick;
  bit m_done = 0, m_err = 0;

  function automatic int beats(input logic [3:0] code);
    if (code == 4'd3) return 1;
    if (code == 4'd8) return 2;
    if (code == 4'd9) return 4;
    return 0;
  endfunction

  function automatic int pick_req(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @* m_pick = pick_req(req, m_ptr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0; m_owner <= 0; m_ptr <= 0; m_size <= 0; m_write <= 0;
      m_tmo <= 0; m_moved <= 0; m_done <= 0; m_err <= 0;
    end else begin
      m_done <= 0;
      m_err  <= 0;
      case (m_phase)
        0: if (m_pick >= 0) begin
          m_owner <= m_pick;
          m_size  <= int'(size[m_pick*4 +: 4]);
          m_write <= int'(wr[m_pick]);
          m_tmo   <= 0;
          if (beats(size[m_pick*4 +: 4]) == 0) begin
            m_phase <= 3; m_err <= 1;
          end else m_phase <= 1;
        end
        1: if (bus_error || m_tmo == TO) begin
          m_phase <= 3; m_err <= 1;
        end else if (!req[m_owner]) m_phase <= 0;
        else if (bus_grant) begin
          m_phase <= 2; m_moved <= 0; m_tmo <= 0;
        end else m_tmo <= m_tmo + 1;
        2: if (bus_error || m_tmo == TO) begin
          m_phase <= 3; m_err <= 1;
        end else if (bus_valid) begin
          m_tmo <= 0;
          if (m_moved + 1 == beats(4'(m_size))) begin
            m_phase <= 3; m_done <= 1;
          end else m_moved <= m_moved + 1;
        end else m_tmo <= m_tmo + 1;
        default: begin
          m_ptr <= (m_owner + 1) % N;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg, ed, ee;
    logic         ebr;
    if (chk_en) begin
      eg = '0; ed = '0; ee = '0;
      if (m_phase == 2) eg[m_owner] = 1'b1;
      if (m_phase == 3 && m_done) ed[m_owner] = 1'b1;
      if (m_phase == 3 && m_err) ee[m_owner] = 1'b1;
      ebr = (m_phase == 1) || (m_phase == 2);
      check("grant_o", grant_o, eg);
      check("done_o", done_o, ed);
      check("error_o", error_o, ee);
      check("bus_req_o", bus_req_o, ebr);
      check("bus_write_o", bus_write_o, ebr ? m_write : 0);
      check("bus_size_o", bus_size_o, ebr ? m_size : 0);
      check("busy_o", busy_o, m_phase != 0);
      check("owner_o", owner_o, m_owner);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  logic [6:0] pat;
  int         r;

  initial begin
    step();
    step();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("reset busy", busy_o, 0);
    check("reset owner", owner_o, 0);
    check("reset bus_req", bus_req_o, 0);

    // Single read, size 3, grant two cycles after the request.
    req = 3'b001; size = 12'h003; wr = '0;
    step();
    check("t1 bus_req", bus_req_o, 1);
    check("t1 bus_size", bus_size_o, 3);
    check("t1 no grant yet", grant_o, 0);
    step();
    bus_grant = 1; step();
    check("t1 grant", grant_o, 3'b001);
    bus_grant = 0; bus_valid = 1; step();
    check("t1 done", done_o, 3'b001);
    check("t1 grant dropped", grant_o, 0);
    check("t1 busy in bubble", busy_o, 1);
    req = '0; bus_valid = 0; step();
    check("t1 idle", busy_o, 0);

    // Tie from pointer 0: read then write, next tie back to read.
    do_reset();
    req = 3'b011; size = 12'h088; wr = 3'b010;
    step();
    check("t2 owner read", owner_o, 0);
    check("t2 dir read", bus_write_o, 0);
    check("t2 size", bus_size_o, 8);
    bus_grant = 1; step();
    check("t2 grant read", grant_o, 3'b001);
    bus_grant = 0; bus_valid = 1; step();
    check("t2 not done after beat 1", done_o, 0);
    step();
    check("t2 done read", done_o, 3'b001);
    req = 3'b010; bus_valid = 0; step();
    step();
    check("t2 owner write", owner_o, 1);
    check("t2 dir write", bus_write_o, 1);
    bus_grant = 1; step();
    check("t2 grant write", grant_o, 3'b010);
    bus_grant = 0; bus_valid = 1; step(); step();
    check("t2 done write", done_o, 3'b010);
    req = '0; bus_valid = 0; step();
    req = 3'b011; step();
    check("t2 tie back to read", owner_o, 0);
    req = '0; step();
    check("t2 withdraw idle", busy_o, 0);
    check("t2 withdraw no error", error_o, 0);

    // Size 9 write, beats at cycles 1,3,4,7.
    req = 3'b010; size = 12'h090; wr = 3'b010;
    step();
    check("t3 owner", owner_o, 1);
    bus_grant = 1; step();
    bus_grant = 0;
    pat = 7'b1001101;
    for (int k = 0; k < 7; k++) begin
      bus_valid = pat[k];
      step();
      if (k < 6) begin
        check("t3 grant held", grant_o, 3'b010);
        check("t3 no early done", done_o, 0);
      end else begin
        check("t3 done", done_o, 3'b010);
      end
    end
    req = '0; bus_valid = 0; step();

    // Bus error on beat 2 of a size-9 read; write waiting behind it.
    req = 3'b011; size = 12'h039; wr = 3'b010;
    step();
    check("t4 owner read", owner_o, 0);
    bus_grant = 1; step();
    bus_grant = 0; bus_valid = 1; step();
    bus_error = 1; step();
    check("t4 error", error_o, 3'b001);
    check("t4 no done", done_o, 0);
    check("t4 grant dropped", grant_o, 0);
    req = 3'b010; bus_valid = 0; bus_error = 0; step(); step();
    check("t4 next owner", owner_o, 1);
    bus_grant = 1; step();
    bus_grant = 0; bus_valid = 1; step();
    check("t4 write done", done_o, 3'b010);
    req = '0; bus_valid = 0; step();

    // Timeout with no bus grant, then an illegal size code.
    req = 3'b001; size = 12'h003; wr = '0;
    step();
    for (int i = 1; i <= TO; i++) begin
      step();
      check("t5 still requesting", bus_req_o, 1);
      check("t5 no early error", error_o, 0);
    end
    step();
    check("t5 timeout error", error_o, 3'b001);
    check("t5 bus_req dropped", bus_req_o, 0);
    req = '0; step();
    req = 3'b001; size = 12'h005; step();
    check("t5 illegal error", error_o, 3'b001);
    check("t5 illegal no bus_req", bus_req_o, 0);
    req = '0; step();

    // Asynchronous reset in the middle of a transfer.
    req = 3'b010; size = 12'h090; wr = 3'b010;
    step();
    bus_grant = 1; step();
    bus_grant = 0; bus_valid = 1; step();
    #2 reset_n = 1'b0;
    #1;
    check("t6 reset grant", grant_o, 0);
    check("t6 reset bus_req", bus_req_o, 0);
    check("t6 reset busy", busy_o, 0);
    check("t6 reset owner", owner_o, 0);
    req = '0; bus_valid = 0; wr = '0;
    step();
    reset_n = 1'b1;
    req = 3'b001; size = 12'h003; step();
    check("t6 fresh bus_req", bus_req_o, 1);
    bus_grant = 1; step();
    bus_grant = 0; bus_valid = 1; step();
    check("t6 fresh done", done_o, 3'b001);
    req = '0; bus_valid = 0; step();

    // Randomized requesters and bus behaviour.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((m_done || m_err) && m_owner == i) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 9);
            if (r < 3) size[4*i +: 4] = 4'd3;
            else if (r < 6) size[4*i +: 4] = 4'd8;
            else if (r < 9) size[4*i +: 4] = 4'd9;
            else size[4*i +: 4] = 4'($urandom_range(0, 15));
            wr[i]  = 1'($urandom_range(0, 1));
            req[i] = 1'b1;
          end
        end else if (m_phase == 1 && m_owner == i && $urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      bus_grant = ($urandom_range(0, 9) < 3);
      bus_valid = 1'($urandom_range(0, 1));
      bus_error = ($urandom_range(0, 49) == 0);
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
